// File: rtl/vga_pkg.sv
// Shared VGA timing constants and colour types for the timing controller
// and the overlay layers that feed it.
package vga_pkg;

    // Default system clocks per pixel (100 MHz sys clock -> 25 MHz pixels).
    localparam int unsigned CLK_DIV_DEF = 4;

    // 640x480 @ 60 Hz horizontal timing, in pixels.
    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    // Vertical timing, in lines.
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Sync windows (inclusive bounds).
    localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_END   = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_END   = V_ACTIVE + V_FP + V_SYNC - 1;

    // Widths shared with the overlay modules.
    localparam int unsigned RGB_W = 12;
    localparam int unsigned CNT_W = 10;

    typedef logic [RGB_W-1:0] rgb_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_s;

    // Unsigned inclusive window test used for the sync decodes.
    function automatic logic in_range(input cnt_t v, input cnt_t lo, input cnt_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Pixel-side and pin-side signals of the VGA timing controller.
// master: the timing controller; slave: overlays / pin sink.
interface vga_timing_ctrl_if
    import vga_pkg::*;
();
    rgb_t       pix_rgb;
    cnt_t       col;
    cnt_t       row;
    logic       video_on;
    logic       pix_en;
    logic       frame_start;
    logic       hs;
    logic       vs;
    logic [3:0] vga_r;
    logic [3:0] vga_g;
    logic [3:0] vga_b;

    modport master (
        input  pix_rgb,
        output col, row, video_on, pix_en, frame_start,
        output hs, vs, vga_r, vga_g, vga_b
    );

    modport slave (
        output pix_rgb,
        input  col, row, video_on, pix_en, frame_start,
        input  hs, vs, vga_r, vga_g, vga_b
    );
endinterface

// File: rtl/vga_timing_ctrl_pix_clk_div.sv
// Pixel-rate divider: counts 0..CLK_DIV-1 and strobes pix_en on the last
// system clock of each pixel period. CLK_DIV must be at least 2 so that
// pix_en is low while the divider is held in reset.
module pix_clk_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic pix_en
);
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    // Next divider value: wrap at the last clock of the pixel.
    always_comb begin
        div_d = div_q + DIV_W'(1);
        if (div_q == DIV_LAST) begin
            div_d = '0;
        end
    end

    // Divider register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign pix_en = (div_q == DIV_LAST);

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing controller: pixel divider, col/row counters, sync decode and a
// one-pixel registered output stage so colour and sync reach the pins with
// identical latency. Totals must not exceed 1024 (10-bit counters).
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV  = vga_pkg::CLK_DIV_DEF,
    parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int unsigned H_FP     = vga_pkg::H_FP,
    parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
    parameter int unsigned H_BP     = vga_pkg::H_BP,
    parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int unsigned V_FP     = vga_pkg::V_FP,
    parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
    parameter int unsigned V_BP     = vga_pkg::V_BP
) (
    input  logic              clk,
    input  logic              rst_n,
    vga_timing_ctrl_if.master vif
);
    localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam cnt_t H_LAST   = CNT_W'(H_TOT - 1);
    localparam cnt_t V_LAST   = CNT_W'(V_TOT - 1);
    localparam cnt_t H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam cnt_t V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam cnt_t HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam cnt_t HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam cnt_t VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam cnt_t VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic pix_en;

    cnt_t col_q, col_d;
    cnt_t row_q, row_d;

    logic video_on;
    logic hs_raw;
    logic vs_raw;

    rgb_s rgb_q, rgb_d;
    logic hs_q, hs_d;
    logic vs_q, vs_d;

    pix_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_clk_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .pix_en (pix_en)
    );

    // Raster position advance: col each pixel, row on col wrap.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (pix_en) begin
            if (col_q == H_LAST) begin
                col_d = '0;
                if (row_q == V_LAST) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + CNT_W'(1);
                end
            end else begin
                col_d = col_q + CNT_W'(1);
            end
        end
    end

    // Raster position registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Decodes of the current position; stable for a whole pixel period.
    always_comb begin
        video_on = (col_q < H_ACT_C) && (row_q < V_ACT_C);
        hs_raw   = ~in_range(col_q, HS_START, HS_END);
        vs_raw   = ~in_range(row_q, VS_START, VS_END);
    end

    // Output stage next values: capture colour and sync at pixel end.
    always_comb begin
        rgb_d = rgb_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        if (pix_en) begin
            rgb_d = video_on ? rgb_s'(vif.pix_rgb) : '0;
            hs_d  = hs_raw;
            vs_d  = vs_raw;
        end
    end

    // Output stage registers; sync idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q <= '0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
        end else begin
            rgb_q <= rgb_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
        end
    end

    assign vif.col         = col_q;
    assign vif.row         = row_q;
    assign vif.video_on    = video_on;
    assign vif.pix_en      = pix_en;
    assign vif.frame_start = pix_en && (col_q == '0) && (row_q == '0);
    assign vif.hs          = hs_q;
    assign vif.vs          = vs_q;
    assign vif.vga_r       = rgb_q.r;
    assign vif.vga_g       = rgb_q.g;
    assign vif.vga_b       = rgb_q.b;

endmodule
